spi_slave_rx: RTL and testbench
===============================

// Module: spi_slave_rx
// PURPOSE
//  SPI mode-0 slave receiver: the receiving end of spi_master_tx on the same sck/ss/mosi link.
//  Oversamples sck/ss/mosi in the clk domain and deserialises DATA_W-bit words.
//  Presents each word on a valid/ready interface to the consuming logic.
//  Flags words lost to backpressure (overrun) and words cut short by ss deassertion (frame_err).
// PARAMETERS
//  DATA_W       8  word width in bits; sck rising edges per word
//  SYNC_STAGES  2  flops in each input synchroniser (sck, ss, mosi); minimum 2
// PORTS
//  clk        in   1       system clock; all state on its rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  sck        in   1       SPI clock from master; idle low; async to clk
//  ss         in   1       slave select, active low; async to clk
//  mosi       in   1       serial data; master changes it on sck fall, slave samples on sck rise
//  data       out  DATA_W  received word; stable while valid=1
//  valid      out  1       data holds an unconsumed word
//  ready      in   1       consumer accepts data when valid && ready on a clk edge
//  busy       out  1       synchronised ss is low (frame in progress)
//  overrun    out  1       sticky; a completed word was dropped
//  frame_err  out  1       one-clk pulse; ss rose mid-word
// BEHAVIOUR
//  Reset: data=0, valid=0, busy=0, overrun=0, frame_err=0; bit count=0; shift reg=0; FSM=IDLE.
//  Sync: sck, ss and mosi each pass through SYNC_STAGES flops, so all three carry equal delay.
//  sck_rise = (sck_s == 1) && (sck_s_prev == 0). The bit is taken from mosi_s in that same cycle.
//  Timing limit: sck high and low phases must each last >= SYNC_STAGES+1 clk periods.
//   Faster sck is out of spec; behaviour is undefined.
//  FSM:
//   IDLE  -> SHIFT when ss_s == 0. sck edges in IDLE are ignored. busy=0.
//   SHIFT -> IDLE when ss_s == 1. busy=1.
//  Shifting in SHIFT, on each sck_rise:
//   Capture the bit and increment the count (0..DATA_W-1).
//   At count == DATA_W-1 the word is complete: count wraps to 0.
//   Further bits with ss still low start the next word (back-to-back words supported).
//   Bit order without the macro: LSB first. The first bit received lands in data[0].
//  Word completion, one cycle after the last sck_rise:
//   valid==0 -> data <= word, valid <= 1.
//   valid==1 && ready==1 in the same cycle -> old word accepted, data <= new word, valid stays 1,
//    no overrun.
//   valid==1 && ready==0 -> new word dropped, data unchanged, overrun <= 1.
//  Handshake: valid && ready -> valid <= 0 next cycle (unless a word completes in that cycle).
//   The same handshake clears overrun.
//  ss_s rising:
//   count != 0 -> frame_err=1 for exactly one cycle; partial word discarded; count <= 0.
//   count == 0 -> no error.
//  sck_rise and ss_s rise in the same cycle: the bit is counted first, then the ss rule applies.
//   So a final bit arriving this way completes the word and raises no frame_err.
//  Async reset mid-frame returns everything to reset values immediately. The next ss fall restarts cleanly.
// CONFIGURATION
//  SPI_SLAVE_RX_MSB_FIRST_EN
//   Defined: MSB first; the word shifts left, and the first bit received ends in data[DATA_W-1].
//   Undefined (default): LSB first, matching the current spi_master_tx bench receiver.
//  No other behaviour changes with the macro.
// TESTING
//  Stimulus: clk period 5 units, sck period 200 units, ss low 100 units before the first sck rise.
//  1 Reset: assert rst_n=0 mid-frame -> data=0, valid=0, busy=0, overrun=0, frame_err=0
//    in the same cycle.
//  2 Single word: LSB-first 0x55, ready=0 -> valid=1, data=0x55 after the 8th sck rise.
//    Then ready=1 -> valid=0 next clk.
//  3 Back-to-back: 0xAA then 0x35 within one ss-low frame, ready=1 -> two valid
//    handshakes (0xAA, 0x35); overrun=0; busy=1 throughout.
//  4 Overrun: 0x12 then 0x34, ready=0 -> data stays 0x12, overrun=1.
//    Then ready=1 -> handshake of 0x12, overrun=0.
//  5 Frame error: 5 bits then ss high -> frame_err pulses 1 clk, no valid.
//    Next frame 0x35 -> data=0x35.
//  6 Macro: bit stream 0,0,1,1,0,1,0,1 (MSB of 0x35 first) -> 0x35 with SPI_SLAVE_RX_MSB_FIRST_EN,
//    0xAC without.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: synchronises sck/ss/mosi, deserialises DATA_W-bit words onto a valid/ready port.
// Define SPI_SLAVE_RX_MSB_FIRST_EN for MSB-first words; the default is LSB first.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              ss,
  input  logic              mosi,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_prev_q;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      shift_q;
  logic                   done_q;
  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   overrun_q;
  logic                   frame_err_q;

  logic                   sck_s;
  logic                   ss_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   last_bit;
  logic [CNT_W-1:0]       cnt_d;
  logic [DATA_W-1:0]      shift_d;

  // Equal-length synchronisers keep sck, ss and mosi aligned with one another.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign last_bit = sck_rise && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (sck_rise) begin
      cnt_d = last_bit ? '0 : cnt_q + 1'b1;
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
      shift_d = {shift_q[DATA_W-2:0], mosi_s};
`else
      shift_d = {mosi_s, shift_q[DATA_W-1:1]};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;

      // shift_q still holds the finished word here: the next sck rise is several clks away.
      if (done_q) begin
        if (!valid_q || ready) begin
          data_q    <= shift_q;
          valid_q   <= 1'b1;
          if (valid_q) overrun_q <= 1'b0;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!ss_s) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          done_q  <= last_bit;
          if (ss_s) begin
            // A bit arriving with the ss rise is counted first, so a completing bit is not an error.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (cnt_d != '0) begin
              frame_err_q <= 1'b1;
              shift_q     <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: reset, single word, back-to-back, overrun, frame error, bit order.
`timescale 1ns/100ps
module tb_spi_slave_rx;

  localparam int DATA_W = 8;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              sck   = 1'b0;
  logic              ss    = 1'b1;
  logic              mosi  = 1'b0;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  int errors = 0;
  int checks = 0;
  int acc_n  = 0;
  int fe_cnt = 0;
  logic [DATA_W-1:0] acc_w [0:63];

  always #2.5 clk = ~clk;

  spi_slave_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sck       (sck),
    .ss        (ss),
    .mosi      (mosi),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .busy      (busy),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  // Record every accepted word and every frame_err cycle.
  always @(posedge clk) begin
    if (rst_n && valid && ready) begin
      acc_w[acc_n[5:0]] <= data;
      acc_n <= acc_n + 1;
    end
    if (rst_n && frame_err) fe_cnt <= fe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream is always sent LSB of w first; expected word depends on the build's bit order.
  function automatic logic [DATA_W-1:0] exp_word(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = w;
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
    for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
`endif
    return r;
  endfunction

  task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = w[i];
      #100 sck = 1'b1;
      #100 sck = 1'b0;
    end
  endtask

  task automatic end_frame();
    #100 ss = 1'b1;
    #100;
  endtask

  initial begin
    // Reset state
    #20;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    #20;

    // Single word, held until ready
    ss = 1'b0;
    send_bits(8'h55, 8);
    check("single_valid", 32'(valid), 32'h1);
    check("single_data", 32'(data), 32'(exp_word(8'h55)));
    check("single_busy", 32'(busy), 32'h1);
    ready = 1'b1;
    #5;
    check("single_valid_clr", 32'(valid), 32'h0);
    check("single_acc_n", 32'(acc_n), 32'd1);
    check("single_acc_w", 32'(acc_w[0]), 32'(exp_word(8'h55)));
    ready = 1'b0;
    end_frame();
    check("single_busy_end", 32'(busy), 32'h0);
    check("single_no_fe", 32'(fe_cnt), 32'd0);

    // Back-to-back words in one frame, consumer always ready
    ready = 1'b1;
    ss = 1'b0;
    send_bits(8'hAA, 8);
    check("b2b_busy1", 32'(busy), 32'h1);
    send_bits(8'h35, 8);
    check("b2b_busy2", 32'(busy), 32'h1);
    end_frame();
    check("b2b_acc_n", 32'(acc_n), 32'd3);
    check("b2b_word1", 32'(acc_w[1]), 32'(exp_word(8'hAA)));
    check("b2b_word2", 32'(acc_w[2]), 32'(exp_word(8'h35)));
    check("b2b_overrun", 32'(overrun), 32'h0);
    check("b2b_valid", 32'(valid), 32'h0);

    // Overrun: second word dropped while the first waits
    ready = 1'b0;
    ss = 1'b0;
    send_bits(8'h12, 8);
    send_bits(8'h34, 8);
    end_frame();
    check("ovr_data", 32'(data), 32'(exp_word(8'h12)));
    check("ovr_valid", 32'(valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    ready = 1'b1;
    #5;
    check("ovr_acc_n", 32'(acc_n), 32'd4);
    check("ovr_acc_w", 32'(acc_w[3]), 32'(exp_word(8'h12)));
    check("ovr_clr", 32'(overrun), 32'h0);
    check("ovr_valid_clr", 32'(valid), 32'h0);

    // Frame error: 5 bits then ss high
    ss = 1'b0;
    send_bits(8'h1F, 5);
    end_frame();
    check("fe_pulses", 32'(fe_cnt), 32'd1);
    check("fe_no_valid", 32'(valid), 32'h0);
    check("fe_acc_n", 32'(acc_n), 32'd4);
    ready = 1'b0;
    ss = 1'b0;
    send_bits(8'h35, 8);
    end_frame();
    check("fe_next_data", 32'(data), 32'(exp_word(8'h35)));
    check("fe_next_valid", 32'(valid), 32'h1);
    check("fe_next_no_fe", 32'(fe_cnt), 32'd1);
    ready = 1'b1;
    #5;
    ready = 1'b0;
    check("fe_next_clr", 32'(valid), 32'h0);

    // Bit order: stream 0,0,1,1,0,1,0,1
    ss = 1'b0;
    send_bits(8'hAC, 8);
    end_frame();
`ifdef SPI_SLAVE_RX_MSB_FIRST_EN
    check("order_data", 32'(data), 32'h35);
`else
    check("order_data", 32'(data), 32'hAC);
`endif

    // Async reset mid-frame with valid and overrun set
    ss = 1'b0;
    send_bits(8'h77, 8);
    check("pre_rst_overrun", 32'(overrun), 32'h1);
    send_bits(8'h03, 3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data), 32'h0);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_overrun", 32'(overrun), 32'h0);
    check("mid_rst_frame_err", 32'(frame_err), 32'h0);
    #4;
    ss = 1'b1;
    #20 rst_n = 1'b1;
    #20;
    ss = 1'b0;
    send_bits(8'h5A, 8);
    end_frame();
    check("post_rst_data", 32'(data), 32'(exp_word(8'h5A)));
    check("post_rst_valid", 32'(valid), 32'h1);
    check("post_rst_no_fe", 32'(fe_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
